// File: rtl/music_pkg.sv
// Shared definitions for the music playback blocks: sequencer states,
// tempo codes, tone constants and the tempo-to-divisor mapping.
package music_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_PLAY   = 2'b01,
        ST_PAUSED = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        TEMPO_NORMAL     = 2'b00,
        TEMPO_FAST       = 2'b01,
        TEMPO_SLOW       = 2'b10,
        TEMPO_NORMAL_ALT = 2'b11
    } tempo_e;

    // Rest tone: divider value that produces no audible note.
    localparam int unsigned NM0 = 100000000;

    // Quarter-beat length in clk cycles for a given tempo code.
    function automatic logic [31:0] tempo_divisor(input logic [1:0] sel,
                                                  input logic [31:0] base);
        logic [31:0] div;
        case (tempo_e'(sel))
            TEMPO_FAST: div = base >> 1;
            TEMPO_SLOW: div = base << 1;
            default:    div = base;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Quarter-beat tick generator: counts enabled cycles up to a tempo-selected
// divisor and pulses tick (combinationally) on the wrapping cycle. The
// divisor is only re-sampled on a clear or a wrap, so a tempo change never
// shortens or stretches a quarter-beat already in progress.
module tick_divider
    import music_pkg::*;
#(
    parameter int unsigned TICK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] tempo_sel,
    output logic       tick
);

    logic [31:0] count_q, count_d;
    logic [31:0] div_q, div_d;

    // Next counter/divisor and wrap detection.
    always_comb begin
        count_d = count_q;
        div_d   = div_q;
        tick    = 1'b0;
        if (clr) begin
            count_d = '0;
            div_d   = tempo_divisor(tempo_sel, 32'(TICK_DIV));
        end else if (en) begin
            if (count_q == div_q - 32'd1) begin
                count_d = '0;
                div_d   = tempo_divisor(tempo_sel, 32'(TICK_DIV));
                tick    = 1'b1;
            end else begin
                count_d = count_q + 32'd1;
            end
        end
    end

    // Counter and divisor registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            div_q   <= 32'(TICK_DIV);
        end else begin
            count_q <= count_d;
            div_q   <= div_d;
        end
    end

endmodule

// File: rtl/beat_sequencer.sv
// Song playback sequencer: IDLE/PLAY/PAUSED control, quarter-beat index for
// the tone ROM, and registered enable/pause/tick/done outputs.
module beat_sequencer
    import music_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 12500000,
    parameter int unsigned LAST_BEAT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       play,
    input  logic       pause_req,
    input  logic       stop,
    input  logic       loop,
    input  logic [1:0] tempo_sel,
    output logic [7:0] ibeatNum,
    output logic       en_b,
    output logic       pause,
    output logic       beat_tick,
    output logic       done
);

    state_e     state_q, state_d;
    logic [7:0] beat_q, beat_d;
    logic       en_b_q, en_b_d;
    logic       pause_q, pause_d;
    logic       beat_tick_q, beat_tick_d;
    logic       done_q, done_d;
    logic       div_en, div_clr, tick;

    tick_divider #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_divider (
        .clk      (clk),
        .rst      (rst),
        .en       (div_en),
        .clr      (div_clr),
        .tempo_sel(tempo_sel),
        .tick     (tick)
    );

    // Next-state, beat index and output decode; stop > play > pause_req.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        div_en      = 1'b0;
        div_clr     = 1'b0;
        beat_tick_d = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (play && !stop) begin
                    state_d = ST_PLAY;
                    beat_d  = '0;
                    div_clr = 1'b1;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                    div_clr = 1'b1;
                end else begin
                    // Counting continues on the pause edge so a coincident
                    // tick still completes before the freeze.
                    div_en = 1'b1;
                    if (tick) begin
                        beat_tick_d = 1'b1;
                        if (beat_q == 8'(LAST_BEAT)) begin
                            beat_d = '0;
                            if (!loop) begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            beat_d = beat_q + 8'd1;
                        end
                    end
                    if (pause_req && state_d == ST_PLAY) begin
                        state_d = ST_PAUSED;
                    end
                end
            end
            ST_PAUSED: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                    div_clr = 1'b1;
                end else if (play || pause_req) begin
                    state_d = ST_PLAY;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
                div_clr = 1'b1;
            end
        endcase
        en_b_d  = (state_d != ST_IDLE);
        pause_d = (state_d == ST_PAUSED);
    end

    // State, beat index and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            en_b_q      <= 1'b0;
            pause_q     <= 1'b0;
            beat_tick_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            en_b_q      <= en_b_d;
            pause_q     <= pause_d;
            beat_tick_q <= beat_tick_d;
            done_q      <= done_d;
        end
    end

    assign ibeatNum  = beat_q;
    assign en_b      = en_b_q;
    assign pause     = pause_q;
    assign beat_tick = beat_tick_q;
    assign done      = done_q;

endmodule
